muldiv: RTL and testbench

Iterative multiply/divide unit in the execute stage, beside the ALU. It takes the same srca/srcb operands and produces the HI/LO pair that mfhi/mflo route into the result mux. It executes mult, multu, div and divu over 33 cycles, and exposes a busy/done handshake so the control unit can stall dependent mfhi/mflo.

---
 rtl/muldiv_if.sv | 32 +++
 rtl/muldiv.sv | 153 +++++++++++++++
 tb/tb_muldiv.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: operand/result bundle between the control unit and muldiv.
//   start  launch an operation (honoured only while idle)
//   op     00 mult, 01 multu, 10 div, 11 divu
//   srca   multiplicand / dividend, also mthi/mtlo write data
//   srcb   multiplier / divisor
//   mthi   write srca into HI (idle only)
//   mtlo   write srca into LO (idle only)
//   busy   operation in progress
//   done   one-cycle pulse when an operation has just written HI/LO
//   hi/lo  HI/LO registers
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, srca, srcb, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv.sv
// muldiv: iterative 32-bit multiply/divide unit producing the HI/LO pair.
// mult/multu use shift-add (one multiplier bit per cycle, LSB first);
// div/divu use restoring division (one quotient bit per cycle, MSB first).
// An operation takes 33 cycles from the start edge to HI/LO update.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears all state
//   bus    muldiv_if.slave: start/op/srca/srcb/mthi/mtlo in,
//          busy/done/hi/lo out (all outputs registered)
module muldiv (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_is_div;
  logic [31:0] r_a;        // multiplicand magnitude
  logic [31:0] r_b;        // divisor magnitude
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_neg_q;    // negate product / quotient
  logic        r_neg_r;    // negate remainder (dividend sign)
  logic        r_div0;
  logic [31:0] r_srca;     // raw dividend, returned in HI on divide by zero
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_madd;
  logic [63:0] w_mul_next;
  logic [32:0] w_dsub;
  logic        w_ge;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_signed = ~bus.op[0];
  assign w_a_neg  = w_signed & bus.srca[31];
  assign w_b_neg  = w_signed & bus.srcb[31];
  assign w_a_mag  = w_a_neg ? (~bus.srca + 32'd1) : bus.srca;
  assign w_b_mag  = w_b_neg ? (~bus.srcb + 32'd1) : bus.srcb;

  // Multiply: acc = {partial product high, remaining multiplier bits}.
  assign w_madd     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
  assign w_mul_next = {w_madd, r_acc[31:1]};

  // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
  // The shifted 33-bit remainder is acc[63:31]; when its top bit is set it
  // already exceeds any 32-bit divisor, so only the low 32 bits need the
  // borrow test and the difference always fits back into 32 bits.
  assign w_dsub     = {1'b0, r_acc[62:31]} - {1'b0, r_b};
  assign w_ge       = r_acc[63] | ~w_dsub[32];
  assign w_div_next = w_ge ? {w_dsub[31:0], r_acc[30:0], 1'b1}
                           : {r_acc[62:0], 1'b0};

  assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (r_cnt == 5'd31) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_srca   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_is_div <= bus.op[1];
            r_a      <= w_a_mag;
            r_b      <= w_b_mag;
            r_acc    <= {32'd0, (bus.op[1] ? w_a_mag : w_b_mag)};
            r_cnt    <= '0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= bus.op[1] & (bus.srcb == 32'd0);
            r_srca   <= bus.srca;
            r_busy   <= 1'b1;
          end else begin
            if (bus.mthi) r_hi <= bus.srca;
            if (bus.mtlo) r_lo <= bus.srca;
          end
        end
        RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 5'd1;
        end
        FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_div0) begin
            r_hi <= r_srca;
            r_lo <= '1;
          end else if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: randomized and directed bench for muldiv against an
// arithmetic reference model (native 64-bit multiply, divide, modulo).
module tb_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if bus();

  muldiv dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference: results straight from 64-bit arithmetic.
  function automatic void model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (o)
      2'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = '1;
        end else if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          h = 32'(r);
          l = 32'(q);
        end else begin
          h = a % b;
          l = a / b;
        end
      end
    endcase
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_rhi; m_lo = m_rlo; m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (bus.start) begin
        model_op(bus.op, bus.srca, bus.srcb, m_rhi, m_rlo);
        m_busy = 1'b1;
        m_left = 33;
      end else begin
        if (bus.mthi) m_hi = bus.srca;
        if (bus.mtlo) m_lo = bus.srca;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
  end

  // Call just after a negedge with the unit idle. noise>=0: inject start(div)
  // + mthi(srca=9) at that busy cycle; noise<0: random junk every busy cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int noise, input logic chk, input string nm,
                        input logic [31:0] eh, input logic [31:0] el);
    int   nbusy;
    logic seen;
    nbusy = 0;
    seen  = 1'b0;
    bus.op = o; bus.srca = a; bus.srcb = b;
    bus.start = 1'b1; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) nbusy++;
        if (noise < 0 && bus.busy) begin
          bus.start = 1'($urandom_range(0, 1));
          bus.mthi  = 1'($urandom_range(0, 1));
          bus.mtlo  = 1'($urandom_range(0, 1));
          bus.op    = 2'($urandom_range(0, 3));
          bus.srca  = $urandom;
          bus.srcb  = $urandom;
        end else if (noise == i) begin
          bus.start = 1'b1; bus.op = 2'b10; bus.mthi = 1'b1; bus.srca = 32'd9;
        end
      end
    end
    check({nm, " done seen"}, 32'(seen), 32'd1);
    if (chk) begin
      check({nm, " busy cycles"}, 32'(nbusy), 32'd33);
      check({nm, " hi"}, bus.hi, eh);
      check({nm, " lo"}, bus.lo, el);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dn;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    bus.start = 1'b0; bus.op = '0; bus.srca = '0; bus.srcb = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    run_op(2'd0, 32'hFFFFFFFE, 32'd3, 99, 1'b1, "mult -2*3", 32'hFFFFFFFF, 32'hFFFFFFFA);
    // Each following op starts in the done cycle of the previous one.
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 99, 1'b1, "multu max", 32'hFFFFFFFE, 32'h00000001);
    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 99, 1'b1, "mult -1*-1", 32'h0, 32'h1);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 99, 1'b1, "div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(2'd3, 32'd7, 32'd2, 99, 1'b1, "divu 7/2", 32'd1, 32'd3);
    run_op(2'd3, 32'hFFFFFFFF, 32'd16, 99, 1'b1, "divu max/16", 32'd15, 32'h0FFFFFFF);
    run_op(2'd3, 32'h1234, 32'd0, 99, 1'b1, "divu by 0", 32'h1234, 32'hFFFFFFFF);
    run_op(2'd2, 32'hFFFFFF00, 32'd0, 99, 1'b1, "div neg by 0", 32'hFFFFFF00, 32'hFFFFFFFF);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 99, 1'b1, "div overflow", 32'h0, 32'h80000000);

    bus.srca = 32'hA5A5A5A5; bus.mtlo = 1'b1;
    @(negedge clk);
    bus.mtlo = 1'b0;
    check("mtlo lo", bus.lo, 32'hA5A5A5A5);
    check("mtlo hi kept", bus.hi, 32'h0);
    check("mtlo no done", 32'(bus.done), 32'd0);
    bus.srca = 32'h5A5A0F0F; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mthi+mtlo hi", bus.hi, 32'h5A5A0F0F);
    check("mthi+mtlo lo", bus.lo, 32'h5A5A0F0F);

    run_op(2'd1, 32'd3, 32'd5, 9, 1'b1, "multu busy-ignore", 32'd0, 32'd15);
    @(negedge clk);
    check("single done pulse", 32'(bus.done), 32'd0);

    bus.op = 2'd3; bus.srca = 32'd100; bus.srcb = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset busy", 32'(bus.busy), 32'd0);
    check("async reset hi", bus.hi, 32'd0);
    check("async reset lo", bus.lo, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("no done after reset", 32'(dn), 32'd0);
    run_op(2'd3, 32'd100, 32'd7, 99, 1'b1, "divu 100/7", 32'd2, 32'd14);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.srca = $urandom;
        bus.mthi = 1'($urandom_range(0, 1));
        bus.mtlo = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
      end
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: b = $urandom;
      endcase
      run_op(o, a, b, -1, 1'b0, "rand", 32'd0, 32'd0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
